// File: rtl/morse_char_assembler.sv
`default_nettype none
// ============================================================================
// morse_char_assembler: collects dot/dash pulses, decodes ITU Morse to ASCII
// and emits chars/spaces on a registered valid/ready port. MORSE_DIGITS_EN
// enables 5-symbol digit decode.  Rev 1.0
// ============================================================================
module morse_char_assembler #(
    parameter logic [7:0] UNKNOWN_CHAR = 8'h3F,
    parameter logic [7:0] SPACE_CHAR   = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot,
    input  logic       dash,
    input  logic       LG,
    input  logic       WG,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       overrun
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_COLLECT    = 2'd1,
        ST_HOLD_CHAR  = 2'd2,
        ST_HOLD_SPACE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] code_q, code_d;
    logic [2:0] len_q, len_d;
    logic       ovf_q, ovf_d;
    logic [7:0] char_out_q, char_out_d;
    logic       char_valid_q, char_valid_d;
    logic       overrun_q, overrun_d;
    logic       last_was_space_q, last_was_space_d;
    logic       pending_space_q, pending_space_d;

    logic       w_sym;
    logic       w_gap;
    logic       w_clr;
    logic       w_accept;
    logic [4:0] w_code_base;
    logic [2:0] w_len_base;
    logic       w_ovf_base;

    // Keyed on {len, code}; shorter patterns carry zeros in the unused high bits.
    function automatic logic [7:0] decode(input logic [4:0] code,
                                          input logic [2:0] len,
                                          input logic       ovf);
        logic [7:0] ch;
        ch = UNKNOWN_CHAR;
        if (!ovf) begin
            case ({len, code})
                {3'd1, 5'b00000}: ch = 8'h45;
                {3'd1, 5'b00001}: ch = 8'h54;
                {3'd2, 5'b00000}: ch = 8'h49;
                {3'd2, 5'b00001}: ch = 8'h41;
                {3'd2, 5'b00010}: ch = 8'h4E;
                {3'd2, 5'b00011}: ch = 8'h4D;
                {3'd3, 5'b00000}: ch = 8'h53;
                {3'd3, 5'b00001}: ch = 8'h55;
                {3'd3, 5'b00010}: ch = 8'h52;
                {3'd3, 5'b00011}: ch = 8'h57;
                {3'd3, 5'b00100}: ch = 8'h44;
                {3'd3, 5'b00101}: ch = 8'h4B;
                {3'd3, 5'b00110}: ch = 8'h47;
                {3'd3, 5'b00111}: ch = 8'h4F;
                {3'd4, 5'b00000}: ch = 8'h48;
                {3'd4, 5'b00001}: ch = 8'h56;
                {3'd4, 5'b00010}: ch = 8'h46;
                {3'd4, 5'b00100}: ch = 8'h4C;
                {3'd4, 5'b00110}: ch = 8'h50;
                {3'd4, 5'b00111}: ch = 8'h4A;
                {3'd4, 5'b01000}: ch = 8'h42;
                {3'd4, 5'b01001}: ch = 8'h58;
                {3'd4, 5'b01010}: ch = 8'h43;
                {3'd4, 5'b01011}: ch = 8'h59;
                {3'd4, 5'b01100}: ch = 8'h5A;
                {3'd4, 5'b01101}: ch = 8'h51;
`ifdef MORSE_DIGITS_EN
                {3'd5, 5'b11111}: ch = 8'h30;
                {3'd5, 5'b01111}: ch = 8'h31;
                {3'd5, 5'b00111}: ch = 8'h32;
                {3'd5, 5'b00011}: ch = 8'h33;
                {3'd5, 5'b00001}: ch = 8'h34;
                {3'd5, 5'b00000}: ch = 8'h35;
                {3'd5, 5'b10000}: ch = 8'h36;
                {3'd5, 5'b11000}: ch = 8'h37;
                {3'd5, 5'b11100}: ch = 8'h38;
                {3'd5, 5'b11110}: ch = 8'h39;
`else
`endif
                default: ch = UNKNOWN_CHAR;
            endcase
        end
        return ch;
    endfunction

    assign w_sym    = dot | dash;
    assign w_gap    = LG | WG;
    assign w_clr    = w_gap && (len_q != 3'd0);
    assign w_accept = char_valid_q & char_ready;

    assign w_code_base = w_clr ? 5'd0 : code_q;
    assign w_len_base  = w_clr ? 3'd0 : len_q;
    assign w_ovf_base  = w_clr ? 1'b0 : ovf_q;

    always_comb begin
        state_d          = state_q;
        char_out_d       = char_out_q;
        char_valid_d     = char_valid_q;
        overrun_d        = overrun_q;
        last_was_space_d = last_was_space_q;
        pending_space_d  = pending_space_q;

        // A gap is applied before a coincident symbol, so the symbol opens the next character.
        code_d = w_code_base;
        len_d  = w_len_base;
        ovf_d  = w_ovf_base;
        if (w_sym) begin
            if (w_len_base == 3'd5) begin
                ovf_d = 1'b1;
            end else begin
                code_d = {w_code_base[3:0], dash};
                len_d  = w_len_base + 3'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (WG && !last_was_space_q) begin
                    char_out_d   = SPACE_CHAR;
                    char_valid_d = 1'b1;
                    state_d      = ST_HOLD_SPACE;
                end else if (w_sym) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_gap) begin
                    char_out_d      = decode(code_q, len_q, ovf_q);
                    char_valid_d    = 1'b1;
                    pending_space_d = WG;
                    state_d         = ST_HOLD_CHAR;
                end
            end
            ST_HOLD_CHAR: begin
                if (w_clr) overrun_d = 1'b1;
                if (w_accept) begin
                    last_was_space_d = 1'b0;
                    if (pending_space_q) begin
                        char_out_d      = SPACE_CHAR;
                        pending_space_d = 1'b0;
                        state_d         = ST_HOLD_SPACE;
                    end else begin
                        char_valid_d = 1'b0;
                        state_d      = (len_d != 3'd0) ? ST_COLLECT : ST_IDLE;
                    end
                end
            end
            ST_HOLD_SPACE: begin
                if (w_clr) overrun_d = 1'b1;
                if (w_accept) begin
                    last_was_space_d = 1'b1;
                    char_valid_d     = 1'b0;
                    state_d          = (len_d != 3'd0) ? ST_COLLECT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            code_q           <= 5'd0;
            len_q            <= 3'd0;
            ovf_q            <= 1'b0;
            char_out_q       <= 8'h00;
            char_valid_q     <= 1'b0;
            overrun_q        <= 1'b0;
            last_was_space_q <= 1'b1;
            pending_space_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            code_q           <= code_d;
            len_q            <= len_d;
            ovf_q            <= ovf_d;
            char_out_q       <= char_out_d;
            char_valid_q     <= char_valid_d;
            overrun_q        <= overrun_d;
            last_was_space_q <= last_was_space_d;
            pending_space_q  <= pending_space_d;
        end
    end

    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_char_assembler.sv
`default_nettype none
// ============================================================================
// tb_morse_char_assembler: directed stimulus against a string-based Morse
// model, compared every cycle, plus literal expectations.  Rev 1.0
// ============================================================================
module tb_morse_char_assembler;

    logic       clk = 1'b0;
    logic       reset, dot, dash, LG, WG, char_ready;
    logic [7:0] char_out;
    logic       char_valid, overrun;

    morse_char_assembler dut (
        .clk        (clk),
        .reset      (reset),
        .dot        (dot),
        .dash       (dash),
        .LG         (LG),
        .WG         (WG),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    string letters [0:25] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                             "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                             "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                             "-.--", "--.."};
    string digits [0:9] = '{"-----", ".----", "..---", "...--", "....-",
                            ".....", "-....", "--...", "---..", "----."};

    function automatic logic [7:0] m_decode(input string p, input bit o);
        if (o) return 8'h3F;
        for (int i = 0; i < 26; i++)
            if (p == letters[i]) return 8'h41 + 8'(i);
`ifdef MORSE_DIGITS_EN
        for (int i = 0; i < 10; i++)
            if (p == digits[i]) return 8'h30 + 8'(i);
`endif
        return 8'h3F;
    endfunction

    // Model: the pending character is a dot/dash string; the output slot is a single held value.
    string      m_pat;
    bit         m_ovf, m_valid, m_is_space, m_pend, m_lws, m_ovr;
    logic [7:0] m_char;
    bit         cmp_en = 1'b0;

    always @(posedge clk) begin
        bit    acc, gap;
        string s;
        if (reset) begin
            m_pat = ""; m_ovf = 0; m_valid = 0; m_is_space = 0;
            m_pend = 0; m_lws = 1; m_ovr = 0; m_char = 8'h00;
        end else begin
            acc = m_valid && char_ready;
            gap = LG || WG;
            if (!m_valid) begin
                if (gap && m_pat.len() > 0) begin
                    m_char = m_decode(m_pat, m_ovf);
                    m_valid = 1; m_is_space = 0; m_pend = WG;
                    m_pat = ""; m_ovf = 0;
                end else if (WG && m_pat.len() == 0 && !m_lws) begin
                    m_char = 8'h20; m_valid = 1; m_is_space = 1;
                end
            end else begin
                if (gap && m_pat.len() > 0) begin
                    m_ovr = 1; m_pat = ""; m_ovf = 0;
                end
                if (acc) begin
                    if (!m_is_space) begin
                        m_lws = 0;
                        if (m_pend) begin
                            m_char = 8'h20; m_is_space = 1; m_pend = 0;
                        end else begin
                            m_valid = 0;
                        end
                    end else begin
                        m_lws = 1; m_valid = 0;
                    end
                end
            end
            if (dot || dash) begin
                s = dash ? "-" : ".";
                if (m_pat.len() < 5) m_pat = {m_pat, s};
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_valid", {7'd0, char_valid}, {7'd0, m_valid});
            check("cyc_overrun", {7'd0, overrun}, {7'd0, m_ovr});
            if (m_valid) check("cyc_char", char_out, m_char);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input bit d, input bit a, input bit l, input bit w);
        dot = d; dash = a; LG = l; WG = w;
        @(posedge clk);
        #2;
        dot = 0; dash = 0; LG = 0; WG = 0;
    endtask

    initial begin
        reset = 1; dot = 0; dash = 0; LG = 0; WG = 0; char_ready = 1;
        tick(2);
        reset = 0;
        cmp_en = 1;
        check("rst_valid", {7'd0, char_valid}, 8'd0);
        check("rst_char", char_out, 8'h00);
        check("rst_overrun", {7'd0, overrun}, 8'd0);

        // A, accepted immediately
        pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
        check("A_char", char_out, 8'h41);
        check("A_model", m_char, 8'h41);
        check("A_valid", {7'd0, char_valid}, 8'd1);
        tick(1);
        check("A_once", {7'd0, char_valid}, 8'd0);

        // B then space, then a redundant word gap
        pulse(0, 1, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        check("B_char", char_out, 8'h42);
        tick(1);
        check("sp_char", char_out, 8'h20);
        check("sp_valid", {7'd0, char_valid}, 8'd1);
        tick(1);
        check("sp_done", {7'd0, char_valid}, 8'd0);
        pulse(0, 0, 0, 1);
        tick(2);
        check("no_dup_sp", {7'd0, char_valid}, 8'd0);

        // Overlong sequence, then a clean E
        repeat (6) pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        check("ovf_char", char_out, 8'h3F);
        check("ovf_model", m_char, 8'h3F);
        tick(1);
        pulse(1, 0, 0, 0); pulse(0, 0, 1, 0);
        check("E_char", char_out, 8'h45);
        tick(1);

        // Simultaneous dot+dash counts as dash
        pulse(1, 1, 0, 0); pulse(0, 0, 1, 0);
        check("both_T", char_out, 8'h54);
        tick(1);

        // Gap with a coincident dot: dot begins the next character
        pulse(0, 1, 0, 0); pulse(1, 0, 1, 0);
        check("coin_T", char_out, 8'h54);
        tick(1);
        pulse(0, 0, 1, 0);
        check("coin_E", char_out, 8'h45);
        tick(1);

        // Output stalled: second character is dropped and overrun latches
        char_ready = 0;
        pulse(1, 0, 0, 0); pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0); pulse(0, 0, 1, 0);
        check("stall_char", char_out, 8'h45);
        check("stall_ovr", {7'd0, overrun}, 8'd1);
        tick(2);
        check("stall_hold", char_out, 8'h45);
        char_ready = 1;
        tick(1);
        check("stall_drain", {7'd0, char_valid}, 8'd0);
        tick(3);
        check("stall_only1", {7'd0, char_valid}, 8'd0);
        check("stall_sticky", {7'd0, overrun}, 8'd1);

        // Five-symbol digit pattern
        pulse(1, 0, 0, 0);
        repeat (4) pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
`ifdef MORSE_DIGITS_EN
        check("digit_1", char_out, 8'h31);
`else
        check("digit_1", char_out, 8'h3F);
`endif
        tick(1);

        // Reset mid-handshake with three symbols accumulated
        char_ready = 0;
        pulse(1, 0, 0, 0); pulse(0, 0, 1, 0);
        repeat (3) pulse(0, 1, 0, 0);
        check("pre_rst_valid", {7'd0, char_valid}, 8'd1);
        reset = 1;
        tick(1);
        reset = 0;
        check("mid_rst_valid", {7'd0, char_valid}, 8'd0);
        check("mid_rst_ovr", {7'd0, overrun}, 8'd0);
        char_ready = 1;
        pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
        check("post_rst_T", char_out, 8'h54);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
